// File: rtl/joy_answer_arbiter_if.sv
// Answer bus between the remote front end and the scoring stage.
// master: the arbiter (drives the decoded answer). slave: the scorer / remote side.
interface joy_answer_arbiter_if;
  logic [7:0] in_hex_joy;
  logic       next_q;
  logic       ans_ready;
  logic       ans_valid;
  logic [3:0] ans_sel;
  logic [1:0] ans_player;
  logic       collision;
  logic       busy;

  modport master (
    input  in_hex_joy, next_q, ans_ready,
    output ans_valid, ans_sel, ans_player, collision, busy
  );

  modport slave (
    output in_hex_joy, next_q, ans_ready,
    input  ans_valid, ans_sel, ans_player, collision, busy
  );
endinterface

// File: rtl/joy_answer_arbiter.sv
// Quiz remote front end: synchronises and debounces the active-low 8-button bus, rejects
// multi-button presses and hands one {player, answer} per press to the scorer (valid/ready).
// Optional build macro: JOY_REPEAT_BLOCK_EN locks a player after each accepted answer until
// next_q pulses.
module joy_answer_arbiter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  joy_answer_arbiter_if.master bus
);

  typedef enum logic [1:0] {StArmed, StDebounce, StValid, StRelease} state_e;

  localparam logic [CNT_W-1:0] CntLast    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntPreLast = CNT_W'(DEBOUNCE_CYCLES - 2);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sync1_q, s_q;
  logic [7:0]       cand_q, cand_d;
  logic [3:0]       sel_q, sel_d;
  logic [1:0]       player_q, player_d;
  logic             collision_q, collision_d;
  logic             col_seen_q, col_seen_d;

  logic [3:0]       low_cnt;
  logic [2:0]       low_idx;
  logic             one_low, multi_low;
  logic [1:0]       cand_player;
  logic [3:0]       cand_sel;
  logic             cand_locked;

  // Two-flop synchroniser; idle bus (all released) is all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 8'hFF;
      s_q     <= 8'hFF;
    end else begin
      sync1_q <= bus.in_hex_joy;
      s_q     <= sync1_q;
    end
  end

  // Count pressed buttons and locate the (single) pressed one.
  always_comb begin
    low_cnt = '0;
    low_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (!s_q[i]) begin
        low_cnt = low_cnt + 4'd1;
        low_idx = 3'(i);
      end
    end
  end

  assign one_low     = (low_cnt == 4'd1);
  assign multi_low   = (low_cnt >= 4'd2);
  // Upper nibble is player 1; within a nibble the MSB is answer 1.
  assign cand_player = low_idx[2] ? 2'd1 : 2'd2;
  assign cand_sel    = 4'd4 - {2'b00, low_idx[1:0]};

`ifdef JOY_REPEAT_BLOCK_EN
  logic [1:0] lock_q, lock_d;

  // Per-player lock: set on transfer, cleared by next_q (clear wins over a same-cycle transfer).
  always_comb begin
    lock_d = lock_q;
    if (bus.next_q) begin
      lock_d = '0;
    end else if (state_q == StValid && bus.ans_ready) begin
      lock_d[player_q[1]] = 1'b1;
    end
  end

  // Lock register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q <= '0;
    end else begin
      lock_q <= lock_d;
    end
  end

  // Player 1 is 2'b01 -> bit 0, player 2 is 2'b10 -> bit 1.
  assign cand_locked = lock_q[cand_player[1]];
`else
  assign cand_locked = 1'b0;
`endif

  // Next-state logic for the press/debounce/handshake/release sequence.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    sel_d       = sel_q;
    player_d    = player_q;
    collision_d = 1'b0;
    // Collision re-arms only once the bus is back to at most one pressed button.
    col_seen_d  = multi_low ? col_seen_q : 1'b0;

    unique case (state_q)
      StArmed: begin
        if (multi_low) begin
          if (!col_seen_q) begin
            collision_d = 1'b1;
            col_seen_d  = 1'b1;
          end
        end else if (one_low && !cand_locked) begin
          cand_d   = s_q;
          sel_d    = cand_sel;
          player_d = cand_player;
          cnt_d    = '0;
          state_d  = StDebounce;
        end
      end
      StDebounce: begin
        if (bus.next_q || (s_q != cand_q)) begin
          cnt_d   = '0;
          state_d = StArmed;
        end else if (cnt_q >= CntPreLast) begin
          cnt_d   = CntLast;
          state_d = StValid;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StValid: begin
        // Either a transfer or a stale answer dropped by next_q.
        if (bus.ans_ready || bus.next_q) begin
          cnt_d   = '0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (s_q != 8'hFF) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          cnt_d   = '0;
          state_d = StArmed;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StArmed;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and captured-answer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StArmed;
      cnt_q       <= '0;
      cand_q      <= 8'hFF;
      sel_q       <= '0;
      player_q    <= '0;
      collision_q <= 1'b0;
      col_seen_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      sel_q       <= sel_d;
      player_q    <= player_d;
      collision_q <= collision_d;
      col_seen_q  <= col_seen_d;
    end
  end

  assign bus.ans_valid  = (state_q == StValid);
  assign bus.ans_sel    = (state_q == StValid) ? sel_q : 4'd0;
  assign bus.ans_player = (state_q == StValid) ? player_q : 2'd0;
  assign bus.collision  = collision_q;
  assign bus.busy       = (state_q != StArmed);

endmodule

// File: tb/tb_joy_answer_arbiter.sv
// Scoreboard bench for joy_answer_arbiter: stimulus pushes expected {player, answer} transfers,
// a negedge monitor pops and compares on every valid&ready cycle.
module tb_joy_answer_arbiter;

  localparam int unsigned Deb = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   col_count;

  logic [5:0] exp_q[$];

  joy_answer_arbiter_if bus ();

  joy_answer_arbiter #(
    .DEBOUNCE_CYCLES(Deb),
    .CNT_W          (5)
  ) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy && n < 300) begin
      tick(1);
      n++;
    end
    check(name, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic pulse_next();
    bus.next_q = 1'b1;
    tick(1);
    bus.next_q = 1'b0;
  endtask

  task automatic settle(input string name);
    wait_idle(name);
    pulse_next();
    tick(2);
  endtask

  task automatic press(input logic [7:0] val, input int hold, input logic [1:0] pl,
                       input logic [3:0] sel, input bit expect_xfer);
    if (expect_xfer) exp_q.push_back({pl, sel});
    bus.in_hex_joy = val;
    tick(hold);
    bus.in_hex_joy = 8'hFF;
  endtask

  // Monitor: count collision pulses, check idle outputs, score transfers.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.collision) col_count++;
      if (!bus.ans_valid) begin
        check("idle_outputs_zero", {26'b0, bus.ans_player, bus.ans_sel}, 32'd0);
      end else if (bus.ans_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got P%0d/%0d expected none",
                   bus.ans_player, bus.ans_sel);
        end else begin
          check("transfer", {26'b0, bus.ans_player, bus.ans_sel}, {26'b0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    col_count      = 0;
    reset          = 1'b0;
    bus.in_hex_joy = 8'hFF;
    bus.next_q     = 1'b0;
    bus.ans_ready  = 1'b0;

    // T1: reset with random bus
    for (int i = 0; i < 4; i++) begin
      bus.in_hex_joy = 8'($urandom);
      tick(1);
      check("t1_reset_outputs", {24'b0, bus.ans_valid, bus.ans_sel, bus.ans_player,
                                 bus.collision}, 32'd0);
      check("t1_reset_busy", {31'b0, bus.busy}, 32'd0);
    end
    bus.in_hex_joy = 8'hFF;
    tick(1);
    reset = 1'b1;
    tick(5);
    check("t1_after_reset", {23'b0, bus.ans_valid, bus.ans_sel, bus.ans_player,
                             bus.collision, bus.busy}, 32'd0);

    // T2: clean press P1/3 with exact latency
    bus.ans_ready = 1'b1;
    exp_q.push_back({2'd1, 4'd3});
    bus.in_hex_joy = 8'hDF;
    tick(Deb + 1);
    check("t2_not_early", {31'b0, bus.ans_valid}, 32'd0);
    tick(1);
    check("t2_latency", {31'b0, bus.ans_valid}, 32'd1);
    tick(1);
    check("t2_single_cycle", {31'b0, bus.ans_valid}, 32'd0);
    tick(1);
    bus.in_hex_joy = 8'hFF;
    settle("t2_idle");

    // T3: bouncing P2/4, nothing until it holds
    for (int i = 0; i < 8; i++) begin
      bus.in_hex_joy = (i % 2 == 0) ? 8'hFE : 8'hFF;
      tick(5);
    end
    press(8'hFE, 25, 2'd2, 4'd4, 1'b1);
    settle("t3_idle");

    // T4: collision pulse, then a clean P1/1
    begin
      int c0;
      c0 = col_count;
      bus.in_hex_joy = 8'h7E;
      tick(10);
      check("t4_collision_once", 32'(col_count), 32'(c0 + 1));
      check("t4_no_valid", {31'b0, bus.ans_valid}, 32'd0);
      bus.in_hex_joy = 8'hFF;
      tick(5);
    end
    press(8'h7F, 25, 2'd1, 4'd1, 1'b1);
    settle("t4_idle");

    // T5: backpressure holds P2/1 through a button release; next_q discards it
    bus.ans_ready = 1'b0;
    bus.in_hex_joy = 8'hF7;
    tick(Deb + 6);
    check("t5_valid_held", {25'b0, bus.ans_valid, bus.ans_player, bus.ans_sel},
          {25'b0, 1'b1, 2'd2, 4'd1});
    bus.in_hex_joy = 8'hFF;
    tick(5);
    check("t5_valid_after_release", {25'b0, bus.ans_valid, bus.ans_player, bus.ans_sel},
          {25'b0, 1'b1, 2'd2, 4'd1});
    pulse_next();
    check("t5_drop_on_next", {31'b0, bus.ans_valid}, 32'd0);
    wait_idle("t5_idle");
    bus.ans_ready = 1'b1;
    tick(2);

    // Reset asserted with an answer pending: outputs clear without a clock edge
    bus.ans_ready = 1'b0;
    bus.in_hex_joy = 8'hEF;
    tick(Deb + 6);
    check("rst_pending_valid", {25'b0, bus.ans_valid, bus.ans_player, bus.ans_sel},
          {25'b0, 1'b1, 2'd1, 4'd4});
    reset = 1'b0;
    #1;
    check("rst_async_clear", {23'b0, bus.ans_valid, bus.ans_sel, bus.ans_player,
                              bus.collision, bus.busy}, 32'd0);
    bus.in_hex_joy = 8'hFF;
    tick(2);
    reset = 1'b1;
    bus.ans_ready = 1'b1;
    tick(4);
    check("rst_recovered_idle", {31'b0, bus.busy}, 32'd0);

`ifdef JOY_REPEAT_BLOCK_EN
    // T6: P1 locked after answering, P2 still answers, next_q unlocks P1
    press(8'h7F, 25, 2'd1, 4'd1, 1'b1);
    wait_idle("t6_p1_first_idle");
    bus.in_hex_joy = 8'hBF;
    tick(25);
    check("t6_p1_locked", {31'b0, bus.busy}, 32'd0);
    bus.in_hex_joy = 8'hFF;
    tick(5);
    press(8'hFB, 25, 2'd2, 4'd2, 1'b1);
    wait_idle("t6_p2_idle");
    pulse_next();
    tick(2);
    press(8'hBF, 25, 2'd1, 4'd2, 1'b1);
    settle("t6_p1_unlocked_idle");
`else
    // Without locking the same player may answer again after release
    press(8'h7F, 25, 2'd1, 4'd1, 1'b1);
    wait_idle("t6_p1_first_idle");
    press(8'hBF, 25, 2'd1, 4'd2, 1'b1);
    settle("t6_p1_repeat_idle");
`endif

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
